// File: rtl/logic8_pipe.sv
// logic8_pipe: two-stage valid/ready pipeline computing an 8-bit bitwise logic op plus result flags.
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   upstream offers op/e1/e2
//   in_ready   operation is accepted this cycle (combinational from out_ready)
//   op         000 NOT e1, 001 AND, 010 OR, 011 XOR, 100 NAND, 101 NOR, 110 XNOR, 111 pass e1
//   e1, e2     operands (e2 unused by NOT and pass)
//   out_valid  s and flags hold a valid result
//   out_ready  downstream consumes the result this cycle
//   s          result
//   zero       s == 0
//   parity     XOR-reduction of s
//   ones       population count of s
//   count      results consumed since reset, wraps at 256
module logic8_pipe (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] op,
    input  logic [7:0] e1,
    input  logic [7:0] e2,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] s,
    output logic       zero,
    output logic       parity,
    output logic [3:0] ones,
    output logic [7:0] count
);
    logic       r_v1;
    logic [2:0] r_op;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic       r_v2;
    logic [7:0] r_s;
    logic       r_zero;
    logic       r_par;
    logic [3:0] r_ones;
    logic [7:0] r_count;
    logic       w_adv2;
    logic       w_acc;
    logic       w_con;
    logic [7:0] w_res;
    logic [3:0] w_ones;

    assign w_adv2    = r_v1 & (~r_v2 | out_ready);
    assign in_ready  = ~r_v1 | w_adv2;
    assign w_acc     = in_valid & in_ready;
    assign w_con     = r_v2 & out_ready;
    assign out_valid = r_v2;
    assign s         = r_s;
    assign zero      = r_zero;
    assign parity    = r_par;
    assign ones      = r_ones;
    assign count     = r_count;

    always_comb begin
        w_res = 8'h00;
        case (r_op)
            3'b000:  w_res = ~r_a;
            3'b001:  w_res = r_a & r_b;
            3'b010:  w_res = r_a | r_b;
            3'b011:  w_res = r_a ^ r_b;
            3'b100:  w_res = ~(r_a & r_b);
            3'b101:  w_res = ~(r_a | r_b);
            3'b110:  w_res = ~(r_a ^ r_b);
            default: w_res = r_a;
        endcase
    end

    always_comb begin
        w_ones = 4'd0;
        for (int i = 0; i < 8; i++)
            w_ones = w_ones + {3'b000, w_res[i]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_op <= 3'b000;
            r_a  <= 8'h00;
            r_b  <= 8'h00;
        end else if (w_acc) begin
            r_v1 <= 1'b1;
            r_op <= op;
            r_a  <= e1;
            r_b  <= e2;
        end else if (w_adv2) begin
            r_v1 <= 1'b0;
        end
    end

    // Flags are computed from the same stage-1 value as s, so they always describe s.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2   <= 1'b0;
            r_s    <= 8'h00;
            r_zero <= 1'b1;
            r_par  <= 1'b0;
            r_ones <= 4'd0;
        end else if (w_adv2) begin
            r_v2   <= 1'b1;
            r_s    <= w_res;
            r_zero <= (w_res == 8'h00);
            r_par  <= ^w_res;
            r_ones <= w_ones;
        end else if (w_con) begin
            r_v2 <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_count <= 8'h00;
        else if (w_con)
            r_count <= r_count + 8'd1;
    end
endmodule

// File: tb/tb_logic8_pipe.sv
// tb_logic8_pipe: randomized self-checking bench for logic8_pipe against a queue-based reference model.
module tb_logic8_pipe;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] op = 3'b000;
    logic [7:0] e1 = 8'h00;
    logic [7:0] e2 = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] s;
    logic       zero;
    logic       parity;
    logic [3:0] ones;
    logic [7:0] count;

    int passed = 0;
    int total  = 0;

    logic [7:0] q[$];
    logic [7:0] cnt_m = 8'h00;
    bit         acc, con, under;
    int         occ;
    logic [7:0] exp_r;
    logic [7:0] got_s;
    logic       got_z, got_p, got_ov, got_rdy;
    logic [3:0] got_o;

    logic8_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .e1(e1), .e2(e2), .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .zero(zero), .parity(parity), .ones(ones), .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        r = a;
        for (int i = 0; i < 8; i++) begin
            case (o)
                3'd0: r[i] = !a[i];
                3'd1: r[i] = a[i] && b[i];
                3'd2: r[i] = a[i] || b[i];
                3'd3: r[i] = a[i] != b[i];
                3'd4: r[i] = !(a[i] && b[i]);
                3'd5: r[i] = !(a[i] || b[i]);
                3'd6: r[i] = a[i] == b[i];
                default: r[i] = a[i];
            endcase
        end
        return r;
    endfunction

    // One clock cycle: drive, sample mid-cycle, update the model, step past the edge.
    task automatic tick(input bit v, input logic [2:0] o, input logic [7:0] a, input logic [7:0] b, input bit rdy);
        in_valid = v; op = o; e1 = a; e2 = b; out_ready = rdy;
        @(negedge clk);
        occ = q.size();
        acc = in_valid && in_ready;
        con = out_valid && out_ready;
        got_s = s; got_z = zero; got_p = parity; got_o = ones; got_ov = out_valid; got_rdy = in_ready;
        under = 1'b0;
        if (con) begin
            if (q.size() > 0) exp_r = q.pop_front();
            else under = 1'b1;
            cnt_m = cnt_m + 8'd1;
        end
        if (acc) q.push_back(ref_op(o, a, b));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
        total++; if (s !== 8'h00) $display("FAIL reset_s got %h want 00", s); else passed++;
        total++; if ({zero, parity, ones} !== {1'b1, 1'b0, 4'd0}) $display("FAIL reset_flags got z%b p%b o%0d want z1 p0 o0", zero, parity, ones); else passed++;
        total++; if (count !== 8'h00) $display("FAIL reset_count got %h want 00", count); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
    endtask

    task automatic test_single();
        tick(1, 3'b001, 8'hF0, 8'h3C, 1);
        total++; if (!acc) $display("FAIL single_accept got in_ready %b want 1", got_rdy); else passed++;
        tick(0, 3'b000, 8'h00, 8'h00, 1);
        total++; if (got_ov !== 1'b0) $display("FAIL single_latency1 got out_valid %b want 0", got_ov); else passed++;
        tick(0, 3'b000, 8'h00, 8'h00, 1);
        total++; if (got_ov !== 1'b1) $display("FAIL single_latency2 got out_valid %b want 1", got_ov); else passed++;
        total++; if ({got_s, got_z, got_p, got_o} !== {8'h30, 1'b0, 1'b0, 4'd2})
            $display("FAIL single_result got s%h z%b p%b o%0d want s30 z0 p0 o2", got_s, got_z, got_p, got_o); else passed++;
        total++; if (count !== 8'd1) $display("FAIL single_count got %0d want 1", count); else passed++;
    endtask

    task automatic test_sweep();
        logic [7:0] want[8] = '{8'h5A, 8'h05, 8'hAF, 8'hAA, 8'hFA, 8'h50, 8'h55, 8'hA5};
        int k = 0;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) tick(1, 3'(i), 8'hA5, 8'h0F, 1);
            else tick(0, 3'b000, 8'h00, 8'h00, 1);
            total++; if (con !== (i >= 2)) $display("FAIL sweep_bubble cycle %0d got consume %b want %b", i, con, i >= 2); else passed++;
            if (con && k < 8) begin
                total++; if (got_s !== want[k]) $display("FAIL sweep_s op%0d got %h want %h", k, got_s, want[k]); else passed++;
                k++;
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] held;
        tick(1, 3'b001, 8'hF0, 8'h3C, 0);
        total++; if (!acc) $display("FAIL bp_acc_a got in_ready %b want 1", got_rdy); else passed++;
        tick(1, 3'b010, 8'hF0, 8'h3C, 0);
        total++; if (!acc) $display("FAIL bp_acc_b got in_ready %b want 1", got_rdy); else passed++;
        tick(1, 3'b011, 8'hF0, 8'h3C, 0);
        total++; if (got_rdy !== 1'b0) $display("FAIL bp_stall_ready got %b want 0", got_rdy); else passed++;
        total++; if ({got_ov, got_s} !== {1'b1, 8'h30}) $display("FAIL bp_head got v%b s%h want v1 s30", got_ov, got_s); else passed++;
        held = got_s;
        tick(1, 3'b011, 8'hF0, 8'h3C, 0);
        total++; if ({got_rdy, got_ov, got_s} !== {1'b0, 1'b1, held}) $display("FAIL bp_stable got r%b v%b s%h want r0 v1 s%h", got_rdy, got_ov, got_s, held); else passed++;
        tick(1, 3'b011, 8'hF0, 8'h3C, 1);
        total++; if (!(acc && con) || got_s !== 8'h30) $display("FAIL bp_release got acc%b con%b s%h want acc1 con1 s30", acc, con, got_s); else passed++;
        tick(0, 3'b000, 8'h00, 8'h00, 1);
        total++; if (!con || got_s !== 8'hFC) $display("FAIL bp_order_b got con%b s%h want con1 sFC", con, got_s); else passed++;
        tick(0, 3'b000, 8'h00, 8'h00, 1);
        total++; if (!con || got_s !== 8'hCC) $display("FAIL bp_order_c got con%b s%h want con1 sCC", con, got_s); else passed++;
    endtask

    task automatic test_zero();
        tick(1, 3'b011, 8'h77, 8'h77, 1);
        tick(0, 3'b000, 8'h00, 8'h00, 1);
        tick(0, 3'b000, 8'h00, 8'h00, 1);
        total++; if ({con, got_s, got_z, got_p, got_o} !== {1'b1, 8'h00, 1'b1, 1'b0, 4'd0})
            $display("FAIL zero_result got c%b s%h z%b p%b o%0d want c1 s00 z1 p0 o0", con, got_s, got_z, got_p, got_o); else passed++;
    endtask

    task automatic test_random(input int n);
        int errs = 0;
        bit stalled = 0;
        logic [7:0] prev_s = 8'h00;
        for (int i = 0; i < n; i++) begin
            tick($urandom_range(0, 1), 3'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 3) != 0);
            if (stalled && (got_ov !== 1'b1 || got_s !== prev_s)) begin
                errs++; $display("FAIL rand_hold cycle %0d got v%b s%h want v1 s%h", i, got_ov, got_s, prev_s);
            end
            if (got_rdy !== !(occ == 2 && !out_ready)) begin
                errs++; $display("FAIL rand_ready cycle %0d got %b occupancy %0d", i, got_rdy, occ);
            end
            if (con && (under || got_s !== exp_r || got_z !== (exp_r == 0) || got_p !== 1'($countones(exp_r) % 2) || got_o !== 4'($countones(exp_r)))) begin
                errs++; $display("FAIL rand_result cycle %0d got s%h z%b p%b o%0d want s%h", i, got_s, got_z, got_p, got_o, exp_r);
            end
            stalled = got_ov && !out_ready;
            prev_s = got_s;
        end
        tick(0, 3'b000, 8'h00, 8'h00, 1);
        tick(0, 3'b000, 8'h00, 8'h00, 1);
        total++; if (errs != 0) $display("FAIL rand_summary got %0d errors want 0", errs); else passed++;
        total++; if (q.size() != 0) $display("FAIL rand_drain got %0d left want 0", q.size()); else passed++;
        total++; if (count !== cnt_m) $display("FAIL rand_count got %0d want %0d", count, cnt_m); else passed++;
    endtask

    task automatic test_wrap();
        logic [7:0] c0 = count;
        int n = 0;
        while (n < 256) begin
            tick(1, 3'($urandom), 8'($urandom), 8'($urandom), 1);
            if (con) n++;
        end
        tick(0, 3'b000, 8'h00, 8'h00, 0);
        total++; if (count !== c0) $display("FAIL wrap_count got %0d want %0d", count, c0); else passed++;
        total++; if (count !== cnt_m) $display("FAIL wrap_model got %0d want %0d", count, cnt_m); else passed++;
        tick(0, 3'b000, 8'h00, 8'h00, 1);
        tick(0, 3'b000, 8'h00, 8'h00, 1);
    endtask

    task automatic test_reset_midflight();
        int stray = 0;
        tick(1, 3'b001, 8'hFF, 8'h0F, 0);
        tick(1, 3'b010, 8'h11, 8'h22, 0);
        in_valid = 0;
        #2 rst_n = 0;
        #1;
        total++; if ({out_valid, s, zero, parity, ones, count} !== {1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 8'h00})
            $display("FAIL midreset_outputs got v%b s%h z%b p%b o%0d c%0d want v0 s00 z1 p0 o0 c0", out_valid, s, zero, parity, ones, count); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL midreset_ready got %b want 1", in_ready); else passed++;
        q.delete();
        cnt_m = 8'h00;
        @(posedge clk); #1 rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            tick(0, 3'b000, 8'h00, 8'h00, 1);
            if (got_ov !== 1'b0) stray++;
        end
        total++; if (stray != 0) $display("FAIL midreset_stale got %0d valid cycles want 0", stray); else passed++;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        test_reset();
        test_single();
        test_sweep();
        test_backpressure();
        test_zero();
        test_random(400);
        test_wrap();
        test_reset_midflight();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/logic8_pipe.md
LOGIC8_PIPE -- requirements
Module: logic8_pipe

Interface
REQ-001 The block SHALL have no parameters; the datapath is fixed at 8 bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  upstream offers an operation this cycle.
REQ-005 in_ready  output  1  block accepts the offered operation this cycle.
REQ-006 op  input  3  operation select, sampled with e1/e2.
REQ-007 e1  input  8  first operand.
REQ-008 e2  input  8  second operand; ignored by single-operand ops.
REQ-009 out_valid  output  1  s and its flags hold a valid result.
REQ-010 out_ready  input  1  downstream consumes the result this cycle.
REQ-011 s  output  8  result.
REQ-012 zero  output  1  s equals 8'h00.
REQ-013 parity  output  1  XOR-reduction of s.
REQ-014 ones  output  4  population count of s (0..8).
REQ-015 count  output  8  number of results consumed since reset.

Function
REQ-016 op encoding SHALL be: 000 NOT e1; 001 AND; 010 OR; 011 XOR; 100 NAND; 101 NOR; 110 XNOR; 111 pass e1.
REQ-017 All operations SHALL be bitwise per bit position; no carries between bits.
REQ-018 Accept SHALL occur when in_valid and in_ready are both 1 in a cycle; op, e1 and e2 are captured into stage 1 that cycle.
REQ-019 Stage 1 SHALL hold the captured op and operands; stage 2 SHALL hold s, zero, parity and ones computed from stage 1.
REQ-020 Stage 2 advance condition: stage 1 valid and (stage 2 empty or out_ready).
REQ-021 in_ready SHALL equal (stage 1 empty) or (stage 2 advances this cycle); it is combinational from out_ready.
REQ-022 Latency SHALL be 2 cycles: an op accepted in cycle N presents out_valid=1 in cycle N+2 when downstream is not stalled.
REQ-023 Throughput SHALL be one op per cycle while out_ready=1 continuously.
REQ-024 While out_valid=1 and out_ready=0, s, zero, parity, ones and out_valid SHALL hold stable.
REQ-025 Stall: with both stages full and out_ready=0, in_ready SHALL be 0 and no input is captured.
REQ-026 Simultaneous consume and accept SHALL both take effect in the same cycle without a bubble.
REQ-027 Stage valid bits SHALL clear when their data moves on and nothing replaces it.
REQ-028 count SHALL increment by 1 on each cycle with out_valid and out_ready both 1, and wrap from 255 to 0.
REQ-029 Flags SHALL be registered alongside s, never computed from a later stage-1 value.
REQ-030 in_valid SHALL be ignored while in_ready=0; upstream holds its offer.

Reset
REQ-031 Asserting rst_n=0 SHALL immediately clear both stage valid bits, s=8'h00, zero=1, parity=0, ones=0 and count=8'h00, regardless of the clock.
REQ-032 in_ready SHALL be 1 while the pipeline is empty, including the first cycle after reset release.
REQ-033 Reset asserted mid-operation SHALL discard in-flight ops; no out_valid pulse follows reset release without a new accept.

Verification
REQ-034 Single op: op=001, e1=8'hF0, e2=8'h3C, out_ready=1 -> two cycles later s=8'h30, zero=0, parity=0, ones=2, count becomes 1 after consume.
REQ-035 Full sweep: e1=8'hA5, e2=8'h0F, op 000..111 back-to-back -> s = 5A, 05, AF, AA, FA, 50, 55, A5 on consecutive cycles, no bubbles.
REQ-036 Backpressure: out_ready=0 with 3 ops offered -> 2 accepted, in_ready=0 afterwards, s stable; out_ready=1 -> third accepted same cycle the first is consumed, order preserved.
REQ-037 Zero result: op=011, e1=e2=8'h77 -> s=8'h00, zero=1, parity=0, ones=0.
REQ-038 Wrap: 256 consumed results -> count returns to 8'h00.
REQ-039 Reset mid-flight: two ops in pipeline, rst_n pulsed low between clock edges -> out_valid=0 at once, all outputs at reset values, no stale result after release.
